// File: rtl/vx_gbar_unit.sv
// vx_gbar_unit -- global barrier unit shared by NUM_CORES core schedulers.
//
// Each barrier ID tracks which cores have arrived (mask), how many have
// arrived (counter), the participant count latched from the first arrival
// (size_m1) and an in_use bit. The arrival that completes a barrier is the
// release: its state is cleared on the accepting edge and a one-cycle
// rsp_valid/rsp_id broadcast follows on the next cycle.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   req_valid    arrival request
//   req_id       barrier ID
//   req_size_m1  participating core count minus one
//   req_core_id  requesting core index
//   req_ready    request accepted when req_valid && req_ready
//   rsp_valid    single-cycle release broadcast
//   rsp_id       released barrier ID (qualified by rsp_valid)
//   err          sticky protocol error (duplicate arrival / size mismatch)
//   timeout      sticky stall-timeout flag
//   busy         any barrier has at least one arrival
//
// Optional feature: define GBAR_TIMEOUT_EN to build the stall-timeout
// counter; otherwise timeout is tied low.

`ifndef NUM_CORES
`define NUM_CORES 4
`endif
`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif
`ifndef NC_WIDTH
`define NC_WIDTH ((`NUM_CORES > 1) ? $clog2(`NUM_CORES) : 1)
`endif
`ifndef NB_WIDTH
`define NB_WIDTH ((`NUM_BARRIERS > 1) ? $clog2(`NUM_BARRIERS) : 1)
`endif

module vx_gbar_unit #(
  parameter int          NUM_CORES    = `NUM_CORES,
  parameter int          NUM_BARRIERS = `NUM_BARRIERS,
  parameter logic [31:0] TIMEOUT      = 32'd1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [`NB_WIDTH-1:0] req_id,
  input  logic [`NC_WIDTH-1:0] req_size_m1,
  input  logic [`NC_WIDTH-1:0] req_core_id,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [`NB_WIDTH-1:0] rsp_id,
  output logic                 err,
  output logic                 timeout,
  output logic                 busy
);

  localparam int NCW = `NC_WIDTH;
  localparam int NBW = `NB_WIDTH;

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_BARRIERS-1:0][NCW-1:0]       cnt_q, cnt_d;
  logic [NUM_BARRIERS-1:0][NCW-1:0]       size_q, size_d;
  logic [NUM_BARRIERS-1:0]                in_use_q, in_use_d;
  logic                                   rsp_valid_q, rsp_valid_d;
  logic [NBW-1:0]                         rsp_id_q, rsp_id_d;
  logic                                   err_q, err_d;
  logic                                   fire;
  logic                                   rel;

  // Ready drops only during the release broadcast cycle, and while in reset.
  assign req_ready = reset & ~rsp_valid_q;
  assign fire      = req_valid & req_ready;
  assign busy      = |in_use_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign err       = err_q;

  always_comb begin
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    in_use_d    = in_use_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rel         = 1'b0;
    if (fire) begin
      if (!in_use_q[req_id]) begin
        // First arrival: counter is 0, so size_m1 == 0 releases at once.
        if (req_size_m1 == '0) begin
          rel = 1'b1;
        end else begin
          in_use_d[req_id]             = 1'b1;
          size_d[req_id]               = req_size_m1;
          mask_d[req_id]               = '0;
          mask_d[req_id][req_core_id]  = 1'b1;
          cnt_d[req_id]                = NCW'(1);
        end
      end else if (mask_q[req_id][req_core_id] || (size_q[req_id] != req_size_m1)) begin
        err_d = 1'b1;
      end else if (cnt_q[req_id] == size_q[req_id]) begin
        // Final arrival: compare happens before increment, so the counter
        // never needs to represent NUM_CORES.
        rel = 1'b1;
      end else begin
        mask_d[req_id][req_core_id] = 1'b1;
        cnt_d[req_id]               = cnt_q[req_id] + NCW'(1);
      end
      if (rel) begin
        mask_d[req_id]   = '0;
        cnt_d[req_id]    = '0;
        in_use_d[req_id] = 1'b0;
        rsp_valid_d      = 1'b1;
        rsp_id_d         = req_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q      <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      in_use_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      in_use_q    <= in_use_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      err_q       <= err_d;
    end
  end

`ifdef GBAR_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (!busy || rel) begin
      tcnt_d = '0;
    end else if (tcnt_q != '1) begin
      tcnt_d = tcnt_q + 32'd1;
      if (tcnt_d == TIMEOUT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT, rel};
  assign timeout = 1'b0;
`endif

endmodule
